// File: rtl/rr_arbiter.sv
// N-requestor arbiter with registered one-hot grant, round-robin or fixed-priority
// selection, and a bounded grant-hold limit while other requestors are waiting.
module rr_arbiter #(
  parameter  int N        = 4,
  parameter  int MAX_HOLD = 4,
  localparam int ID_W     = (N > 2) ? $clog2(N) : 1,
  localparam int HW       = $clog2(MAX_HOLD + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic            mode,
  output logic [N-1:0]    gnt,
  output logic            gnt_valid,
  output logic [ID_W-1:0] gnt_id
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_n;
  logic [ID_W-1:0] ptr, ptr_n;
  logic [HW-1:0]   hold, hold_n;
  logic [N-1:0]    gnt_n;
  logic [ID_W-1:0] id_n;
  logic            arb;
  logic            win_found;
  logic [ID_W-1:0] win_id;
  int              cand;

  // Winner search; the holder is never masked, so round-robin naturally skips it
  // (it sits last in the rotation) while fixed mode may legitimately re-grant it.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = 0;
    for (int k = 0; k < N; k++) begin
      if (mode)
        cand = k;
      else if (int'(ptr) + k >= N)
        cand = int'(ptr) + k - N;
      else
        cand = int'(ptr) + k;
      if (!win_found && req[ID_W'(cand)]) begin
        win_found = 1'b1;
        win_id    = ID_W'(cand);
      end
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    id_n    = gnt_id;
    ptr_n   = ptr;
    hold_n  = hold;
    arb     = 1'b0;
    case (state)
      IDLE: arb = |req;
      BUSY: begin
        if (!req[gnt_id] || (hold == HW'(MAX_HOLD) && |(req & ~gnt)))
          arb = 1'b1;
        else if (hold != HW'(MAX_HOLD))
          hold_n = hold + 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (arb) begin
      if (win_found) begin
        state_n         = BUSY;
        gnt_n           = '0;
        gnt_n[win_id]   = 1'b1;
        id_n            = win_id;
        ptr_n           = (int'(win_id) == N - 1) ? '0 : win_id + 1'b1;
        hold_n          = HW'(1);
      end else begin
        state_n = IDLE;
        gnt_n   = '0;
        hold_n  = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      ptr       <= '0;
      hold      <= '0;
    end else begin
      state     <= state_n;
      gnt       <= gnt_n;
      gnt_valid <= |gnt_n;
      gnt_id    <= id_n;
      ptr       <= ptr_n;
      hold      <= hold_n;
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Vector-table bench for rr_arbiter (N=4, MAX_HOLD=4): per-cycle expectations go
// through a one-deep scoreboard queue; a random phase then checks grant invariants.
module tb_rr_arbiter;

  logic       clock;
  logic       reset;
  logic [3:0] req;
  logic       mode;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;

  rr_arbiter #(.N(4), .MAX_HOLD(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .mode      (mode),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       mode;
    logic [3:0] egnt;
    logic [1:0] eid;
  } vec_t;

  typedef struct {
    int         row;
    logic [3:0] egnt;
    logic       evld;
    logic [1:0] eid;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic void add(input logic r, input logic [3:0] q, input logic m,
                              input logic [3:0] eg, input logic [1:0] ei);
    vec_t v;
    v.rst = r; v.req = q; v.mode = m; v.egnt = eg; v.eid = ei;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic compare_pop();
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("gnt", e.row, 32'(gnt), 32'(e.egnt));
      check("gnt_valid", e.row, 32'(gnt_valid), 32'(e.evld));
      check("gnt_id", e.row, 32'(gnt_id), 32'(e.eid));
    end
  endtask

  initial begin
    exp_t e;
    int   idx;
    logic [3:0] one;
    reset = 1'b1;
    req   = '0;
    mode  = 1'b0;

    // reset held with all requesting, then round-robin saturation
    add(1, 4'b1111, 0, 4'b0000, 0);
    add(1, 4'b1111, 0, 4'b0000, 0);
    for (int g = 0; g < 4; g++)
      for (int c = 0; c < 4; c++) begin
        one = 4'b0001 << g;
        add(0, 4'b1111, 0, one, 2'(g));
      end
    add(0, 4'b1111, 0, 4'b0001, 0);
    // early release to a waiting requestor, then release to idle
    add(0, 4'b1100, 0, 4'b0100, 2);
    add(0, 4'b1000, 0, 4'b1000, 3);
    add(0, 4'b0100, 0, 4'b0100, 2);
    add(0, 4'b0000, 0, 4'b0000, 2);
    add(0, 4'b0000, 0, 4'b0000, 2);
    // lone requestor keeps the grant, competitor wins once hold has saturated
    for (int c = 0; c < 20; c++) add(0, 4'b0100, 0, 4'b0100, 2);
    add(0, 4'b0101, 0, 4'b0001, 0);
    add(0, 4'b0000, 0, 4'b0000, 0);
    // fixed priority re-grants index 1; mode switch mid-grant takes effect at expiry
    for (int c = 0; c < 9; c++) add(0, 4'b1010, 1, 4'b0010, 1);
    for (int c = 0; c < 3; c++) add(0, 4'b1010, 0, 4'b0010, 1);
    add(0, 4'b1010, 0, 4'b1000, 3);
    // reset mid-grant clears the pointer
    add(0, 4'b0011, 0, 4'b0001, 0);
    add(0, 4'b0010, 0, 4'b0010, 1);
    add(1, 4'b0011, 0, 4'b0000, 0);
    add(0, 4'b0011, 0, 4'b0001, 0);
    add(0, 4'b0110, 0, 4'b0010, 1);
    add(1, 4'b0110, 0, 4'b0000, 0);
    add(0, 4'b0110, 0, 4'b0010, 1);
    add(0, 4'b0000, 0, 4'b0000, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clock);
      compare_pop();
      reset = tbl[i].rst;
      req   = tbl[i].req;
      mode  = tbl[i].mode;
      e.row  = i;
      e.egnt = tbl[i].egnt;
      e.evld = (tbl[i].egnt != 4'b0000);
      e.eid  = tbl[i].eid;
      sb.push_back(e);
    end
    @(negedge clock);
    compare_pop();

    // random traffic: grant must stay one-hot/zero and agree with gnt_valid and gnt_id
    for (int c = 0; c < 200; c++) begin
      reset = 1'b0;
      req   = 4'($urandom_range(0, 15));
      mode  = ($urandom_range(0, 7) == 0);
      @(negedge clock);
      check("onehot0", 1000 + c, 32'($onehot0(gnt)), 32'd1);
      check("valid_or", 1000 + c, 32'(gnt_valid), 32'(gnt != 4'b0000));
      if (gnt != 4'b0000) begin
        idx = 0;
        for (int b = 0; b < 4; b++) if (gnt[b]) idx = b;
        check("id_agree", 1000 + c, 32'(gnt_id), 32'(idx));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
